// File: rtl/config_loader_if.sv
// config_loader_if
// Bundles the framed input stream and the switch-box configuration bus.
//   master : upstream stream source (drives cfg_in_*, observes status/config)
//   slave  : config_loader (accepts cfg_in_*, drives ready, config bus, status)
// Signals:
//   cfg_in_data[31:0], cfg_in_valid, cfg_in_ready : word stream handshake
//   config_data[31:0], config_en[NUM_TILES-1:0]   : broadcast word + one-hot strobe
//   busy, done, error                             : frame status
interface config_loader_if #(
    parameter int NUM_TILES = 16
);
    logic [31:0]          cfg_in_data;
    logic                 cfg_in_valid;
    logic                 cfg_in_ready;
    logic [31:0]          config_data;
    logic [NUM_TILES-1:0] config_en;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output cfg_in_data, cfg_in_valid,
        input  cfg_in_ready, config_data, config_en, busy, done, error
    );

    modport slave (
        input  cfg_in_data, cfg_in_valid,
        output cfg_in_ready, config_data, config_en, busy, done, error
    );
endinterface

// File: rtl/config_loader.sv
// config_loader
// Decodes a framed 32-bit stream (header, payload words, optional checksum)
// and writes each payload word to one switch box via config_data/config_en.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : config_loader_if.slave (stream in, config bus out, busy/done/error)
// Parameters: NUM_TILES (config_en width), ADDR_W (tile address width, <= 8).
// Optional feature: define CONFIG_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum word per frame (state CHECK).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a header word
// S_LOAD  | consuming payload words, one strobe per in-range word
// S_CHECK | waiting for the checksum word (checksum build only)
module config_loader #(
    parameter int NUM_TILES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic            clk,
    input  logic            reset,
    config_loader_if.slave  bus
);
    localparam logic [7:0]           MAGIC   = 8'hC5;
    localparam logic [NUM_TILES-1:0] EN_ONE  = {{(NUM_TILES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD
`ifdef CONFIG_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [7:0]           rem_q, rem_d;
    logic [31:0]          data_q, data_d;
    logic [NUM_TILES-1:0] en_q, en_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 ready_q;
    logic                 hs;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0]          csum_q, csum_d;
`endif

    // Ready is 1 in every state, so it only needs to track reset.
    assign hs = bus.cfg_in_valid & ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ready_q <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            en_q    <= en_d;
            done_q  <= done_d;
            error_q <= error_d;
            ready_q <= 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        en_d    = '0;
        done_d  = 1'b0;
        error_d = error_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (bus.cfg_in_data[31:24] == MAGIC && bus.cfg_in_data[23:16] != 8'd0) begin
                        addr_d  = bus.cfg_in_data[ADDR_W-1:0];
                        rem_d   = bus.cfg_in_data[23:16];
                        state_d = S_LOAD;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (hs) begin
                    data_d = bus.cfg_in_data;
                    // Out-of-range addresses still consume the word, just no strobe.
                    if (32'(addr_q) < 32'(NUM_TILES)) begin
                        en_d = EN_ONE << addr_q;
                    end else begin
                        error_d = 1'b1;
                    end
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 8'd1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.cfg_in_data;
                    if (rem_q == 8'd1) begin
                        state_d = S_CHECK;
                    end
`else
                    if (rem_q == 8'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (hs) begin
                    if (bus.cfg_in_data != csum_q) begin
                        error_d = 1'b1;
                    end
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cfg_in_ready = ready_q;
    assign bus.config_data  = data_q;
    assign bus.config_en    = en_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = done_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;
    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    config_loader_if #(.NUM_TILES(16)) bus ();
    config_loader_if #(.NUM_TILES(12)) bus12 ();

    config_loader #(.NUM_TILES(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    config_loader #(.NUM_TILES(12), .ADDR_W(4)) dut12 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus12.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Apply one word, let one rising edge pass, return 1ns after it.
    task automatic drive(input logic [31:0] w, input logic v);
        bus.cfg_in_data  = w;
        bus.cfg_in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic drive12(input logic [31:0] w, input logic v);
        bus12.cfg_in_data  = w;
        bus12.cfg_in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tog_exp [4];
        n_total = 0;
        n_bad   = 0;
        reset = 1'b1;
        bus.cfg_in_data    = '0;
        bus.cfg_in_valid   = 1'b0;
        bus12.cfg_in_data  = '0;
        bus12.cfg_in_valid = 1'b0;

        // Reset values
        @(posedge clk);
        #1;
        check_val("rst_ready", 32'(bus.cfg_in_ready), 32'd0);
        check_val("rst_data",  bus.config_data, 32'd0);
        check_val("rst_en",    32'(bus.config_en), 32'd0);
        check_val("rst_busy",  32'(bus.busy), 32'd0);
        check_val("rst_done",  32'(bus.done), 32'd0);
        check_val("rst_error", 32'(bus.error), 32'd0);
        reset = 1'b0;
        drive(32'h0, 1'b0);
        check_val("ready_after_rst", 32'(bus.cfg_in_ready), 32'd1);

        // Basic frame: START=3, COUNT=2
        drive(32'hC502_0003, 1'b1);
        check_val("hdr_busy", 32'(bus.busy), 32'd1);
        check_val("hdr_en",   32'(bus.config_en), 32'd0);
        drive(32'hA5A5_0001, 1'b1);
        check_val("p1_en",   32'(bus.config_en), 32'h0008);
        check_val("p1_data", bus.config_data, 32'hA5A5_0001);
        check_val("p1_done", 32'(bus.done), 32'd0);
        drive(32'h0000_FFFF, 1'b1);
        check_val("p2_en",   32'(bus.config_en), 32'h0010);
        check_val("p2_data", bus.config_data, 32'h0000_FFFF);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        check_val("p2_done", 32'(bus.done), 32'd0);
        drive(32'hA5A5_FFFE, 1'b1);
        check_val("ck1_en", 32'(bus.config_en), 32'd0);
`endif
        check_val("f1_done",  32'(bus.done), 32'd1);
        check_val("f1_error", 32'(bus.error), 32'd0);
        drive(32'h0, 1'b0);
        check_val("idle_en",   32'(bus.config_en), 32'd0);
        check_val("idle_done", 32'(bus.done), 32'd0);
        check_val("idle_hold", bus.config_data, 32'h0000_FFFF);
        check_val("idle_busy", 32'(bus.busy), 32'd0);

        // Bad magic
        drive(32'h3301_0000, 1'b1);
        check_val("bad_en",    32'(bus.config_en), 32'd0);
        check_val("bad_error", 32'(bus.error), 32'd1);
        check_val("bad_busy",  32'(bus.busy), 32'd0);
        drive(32'h0, 1'b0);
        check_val("bad_sticky", 32'(bus.error), 32'd1);
        drive(32'hC501_0005, 1'b1);
        check_val("after_bad_busy", 32'(bus.busy), 32'd1);
        drive(32'h1234_5678, 1'b1);
        check_val("after_bad_en",   32'(bus.config_en), 32'h0020);
        check_val("after_bad_data", bus.config_data, 32'h1234_5678);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        drive(32'h1234_5678, 1'b1);
`endif
        check_val("after_bad_done",  32'(bus.done), 32'd1);
        check_val("after_bad_error", 32'(bus.error), 32'd1);

        // Valid toggling, START=14 COUNT=4, address wraps 15 -> 0
        tog_exp[0] = 32'h4000;
        tog_exp[1] = 32'h8000;
        tog_exp[2] = 32'h0001;
        tog_exp[3] = 32'h0002;
        drive(32'h0, 1'b0);
        drive(32'hC504_000E, 1'b1);
        drive(32'h0, 1'b0);
        check_val("tog_gap_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(32'h1111_0000 + 32'(i), 1'b1);
            check_val("tog_en",   32'(bus.config_en), tog_exp[i]);
            check_val("tog_data", bus.config_data, 32'h1111_0000 + 32'(i));
            drive(32'hDEAD_BEEF, 1'b0);
            check_val("tog_gap_en", 32'(bus.config_en), 32'd0);
`ifdef CONFIG_LOADER_CHECKSUM_EN
            check_val("tog_gap_busy", 32'(bus.busy), 32'd1);
`else
            check_val("tog_gap_busy", 32'(bus.busy), (i == 3) ? 32'd0 : 32'd1);
`endif
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        drive(32'h0000_0000, 1'b1);
        check_val("tog_ck_done", 32'(bus.done), 32'd1);
        drive(32'h0, 1'b0);
`endif

        // Reset mid-frame, START=0 COUNT=5
        drive(32'hC505_0000, 1'b1);
        drive(32'hCAFE_0000, 1'b1);
        check_val("mid_p1_en", 32'(bus.config_en), 32'h0001);
        drive(32'hCAFE_0001, 1'b1);
        check_val("mid_p2_en", 32'(bus.config_en), 32'h0002);
        bus.cfg_in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_en",    32'(bus.config_en), 32'd0);
        check_val("mid_rst_data",  bus.config_data, 32'd0);
        check_val("mid_rst_busy",  32'(bus.busy), 32'd0);
        check_val("mid_rst_error", 32'(bus.error), 32'd0);
        check_val("mid_rst_ready", 32'(bus.cfg_in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(32'h0, 1'b0);
        check_val("post_rst_en",    32'(bus.config_en), 32'd0);
        check_val("post_rst_ready", 32'(bus.cfg_in_ready), 32'd1);
        drive(32'h0, 1'b0);
        check_val("post_rst_en2", 32'(bus.config_en), 32'd0);
        drive(32'hC501_0007, 1'b1);
        drive(32'h7777_7777, 1'b1);
        check_val("fresh_en",   32'(bus.config_en), 32'h0080);
        check_val("fresh_data", bus.config_data, 32'h7777_7777);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        drive(32'h7777_7777, 1'b1);
`endif
        check_val("fresh_done",  32'(bus.done), 32'd1);
        check_val("fresh_error", 32'(bus.error), 32'd0);
        drive(32'h0, 1'b0);

`ifdef CONFIG_LOADER_CHECKSUM_EN
        // Checksum good, then bad
        drive(32'hC502_0000, 1'b1);
        drive(32'h0F0F_0F0F, 1'b1);
        drive(32'hFFFF_0000, 1'b1);
        check_val("ck_p2_done", 32'(bus.done), 32'd0);
        check_val("ck_p2_busy", 32'(bus.busy), 32'd1);
        drive(32'hF0F0_0F0F, 1'b1);
        check_val("ck_good_done",  32'(bus.done), 32'd1);
        check_val("ck_good_error", 32'(bus.error), 32'd0);
        check_val("ck_good_en",    32'(bus.config_en), 32'd0);
        drive(32'hC502_0000, 1'b1);
        drive(32'h0F0F_0F0F, 1'b1);
        drive(32'hFFFF_0000, 1'b1);
        drive(32'h0000_0000, 1'b1);
        check_val("ck_bad_done",  32'(bus.done), 32'd1);
        check_val("ck_bad_error", 32'(bus.error), 32'd1);
        drive(32'h0, 1'b0);
`endif

        // NUM_TILES=12: START=11 COUNT=3, addresses 12 and 13 out of range
        drive12(32'hC503_000B, 1'b1);
        drive12(32'hAAAA_0001, 1'b1);
        check_val("t12_p1_en",    32'(bus12.config_en), 32'h0800);
        check_val("t12_p1_error", 32'(bus12.error), 32'd0);
        drive12(32'hAAAA_0002, 1'b1);
        check_val("t12_p2_en",    32'(bus12.config_en), 32'd0);
        check_val("t12_p2_error", 32'(bus12.error), 32'd1);
        check_val("t12_p2_data",  bus12.config_data, 32'hAAAA_0002);
        drive12(32'hAAAA_0003, 1'b1);
        check_val("t12_p3_en", 32'(bus12.config_en), 32'd0);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        drive12(32'hAAAA_0000, 1'b1);
`endif
        check_val("t12_done",  32'(bus12.done), 32'd1);
        check_val("t12_error", 32'(bus12.error), 32'd1);
        drive12(32'h0, 1'b0);
        check_val("t12_busy", 32'(bus12.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/config_loader.md
# config_loader

Configuration front-end for the tile array. Accepts a framed 32-bit word stream (valid/ready), decodes a header word, and drives the shared `config_data` bus plus a one-hot `config_en` strobe to the addressed switch boxes. It sits directly upstream of every switch box's `config_data`/`config_en` inputs. Each switch box captures the word on the rising edge where its strobe is high.

## Interface
- `NUM_TILES`, 16: number of downstream switch boxes; width of `config_en`.
- `ADDR_W`, 4: tile address width; must satisfy 2^ADDR_W >= NUM_TILES; max 8.
- `clk` input 1: single clock; all state on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state and outputs immediately.
- `cfg_in_data` input 32: stream word (header, payload or checksum).
- `cfg_in_valid` input 1: `cfg_in_data` is valid.
- `cfg_in_ready` output 1: loader accepts a word this cycle; handshake = valid & ready.
- `config_data` output 32: registered payload broadcast to all switch boxes.
- `config_en` output NUM_TILES: registered one-hot write strobe, bit i = tile i.
- `busy` output 1: frame in progress (state != IDLE).
- `done` output 1: one-cycle pulse when a frame completes.
- `error` output 1: sticky error flag; cleared only by `reset`.

## Operation
- Header word: [31:24] magic 8'hC5; [23:16] COUNT, payload words, 1..255; [ADDR_W-1:0] START tile address; other bits ignored.
- States:
  - IDLE: `cfg_in_ready`=1; on handshake with a valid header, latch START into the address counter and COUNT into the remaining counter, then go to LOAD.
  - Bad magic or COUNT=0: set `error`, stay in IDLE, word discarded.
  - LOAD: `cfg_in_ready`=1; on each handshake, register the word into `config_data`.
    - If address < NUM_TILES, assert `config_en[address]`; otherwise no strobe and set `error`. The word is still consumed.
    - Address increments by 1 with ADDR_W-bit wrap. Remaining decrements by 1.
    - On the last word (remaining=1): go to IDLE and pulse `done`. Under the checksum option, go to CHECK instead.
- `config_data` holds its last value between strobes and never returns to 0 except on reset.
- No handshake (valid low): state, counters and outputs hold; `config_en` = 0.

## Timing
- Reset values: `config_data`=0, `config_en`=0, `cfg_in_ready`=0 while `reset` is high, then 1 from the first cycle after release. `busy`=0, `done`=0, `error`=0, state IDLE.
- Latency: payload handshake at edge N gives `config_data` and `config_en` valid during cycle N+1. The switch box captures at edge N+1.
- `config_en` is high for exactly one cycle per accepted in-range payload. At most one bit is set.
- Back-to-back payloads: one word per cycle sustained, no bubbles. A new header is accepted the cycle after `done`.
- `done` is high in the cycle after the final payload handshake (or after the checksum handshake), coincident with the last `config_en`.
- `reset` asserted mid-frame: frame abandoned, all outputs cleared asynchronously. No partial strobe is issued after release.

## Configuration
- Macro `CONFIG_LOADER_CHECKSUM_EN`.
- Defined: after the last payload, state CHECK expects one extra word equal to the XOR of all payload words in the frame.
  - CHECK has `cfg_in_ready`=1 and issues no strobe.
  - A mismatch sets `error`. Both outcomes return to IDLE and pulse `done`.
  - Already-written tiles are not rolled back.
- Not defined: no CHECK state and no checksum word; a frame ends with its last payload.

## Test plan
- Reset release, then header 32'hC502_0003 and payloads 32'hA5A5_0001, 32'h0000_FFFF with valid held high:
  - `config_en`=16'h0008 then 16'h0010 on consecutive cycles.
  - `config_data` follows one cycle after each handshake.
  - `done` pulses with the second strobe; `error`=0.
- Header 32'h3301_0000 (bad magic): no strobe, `error`=1 and stays 1, next valid header still processed.
- NUM_TILES=12, header START=11, COUNT=3: strobe on tile 11 only, words 2 and 3 (addresses 12, 13) consumed with no strobe, `error`=1.
- Valid toggled 1/0 every cycle during a 4-word frame: exactly 4 one-cycle strobes, none in gap cycles, `busy` high throughout.
- `reset` pulsed after 2 of 5 payloads: outputs go to 0 immediately, no further strobes, and a fresh frame after release works.
- With `CONFIG_LOADER_CHECKSUM_EN`, 2 payloads 32'h0F0F_0F0F and 32'hFFFF_0000:
  - Checksum 32'hF0F0_0F0F gives `error`=0.
  - Checksum 32'h0 gives `error`=1.
  - `done` pulses one cycle after the checksum handshake in both cases.
